// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: buffers LCD opcodes from a host in a small FIFO and issues them
// one at a time to the LCD image controller using its busy/done handshake.
// Illegal opcodes (>11) are discarded. Issuing stops after the write-out
// opcode (0), and seq_done reports when the controller finishes that write-out.
module lcd_cmd_seq #(
    parameter int DEPTH = 8,
    parameter int TMO   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               host_cmd,
    input  logic                     host_push,
    output logic                     host_full,
    output logic [$clog2(DEPTH):0]   fifo_count,
    input  logic                     busy,
    input  logic                     done,
    output logic [3:0]               cmd,
    output logic                     cmd_valid,
    output logic                     seq_done,
    output logic                     err_overflow,
    output logic                     err_illegal,
    output logic                     err_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TMO + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OFFER  = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    // Idle opcode is 4'hF so the controller never sees a stray write (0).
    localparam logic [3:0] OP_IDLE      = 4'hF;
    localparam logic [3:0] OP_WRITE     = 4'h0;
    localparam logic [3:0] OP_MAX_LEGAL = 4'd11;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    logic [3:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [1:0]    state_r;
    logic [TW-1:0] tmo_cnt_r;

    logic          push_ok_s;
    logic          pop_s;
    logic [3:0]    head_s;
    logic [CW-1:0] count_next_s;

    // Pushes are refused whenever the FIFO is full, regardless of a same-cycle pop.
    assign push_ok_s = host_push && !host_full;
    assign pop_s     = (state_r == ST_IDLE) && !busy && (fifo_count != CNT_ZERO);
    assign head_s    = mem_r[rd_ptr_r];

    // Next occupancy from the accepted push and the FSM pop.
    always_comb begin
        count_next_s = fifo_count;
        case ({push_ok_s, pop_s})
            2'b10:   count_next_s = fifo_count + CNT_ONE;
            2'b01:   count_next_s = fifo_count - CNT_ONE;
            default: count_next_s = fifo_count;
        endcase
    end

    // FIFO storage; contents need no reset since pointers/count gate every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= host_cmd;
        end
    end

    // FIFO pointers, occupancy, full flag and sticky overflow error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_count   <= '0;
            host_full    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            fifo_count <= count_next_s;
            host_full  <= (count_next_s == FULL_CNT);
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (host_push && host_full) begin
                err_overflow <= 1'b1;
            end
        end
    end

    // Issue FSM: screen and offer the head, wait out busy, stop after write-out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cmd         <= OP_IDLE;
            cmd_valid   <= 1'b0;
            tmo_cnt_r   <= '0;
            seq_done    <= 1'b0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        if (head_s > OP_MAX_LEGAL) begin
                            err_illegal <= 1'b1;
                        end else begin
                            cmd       <= head_s;
                            cmd_valid <= 1'b1;
                            tmo_cnt_r <= '0;
                            state_r   <= ST_OFFER;
                        end
                    end
                end
                ST_OFFER: begin
                    if (busy) begin
                        cmd_valid <= 1'b0;
                        cmd       <= OP_IDLE;
                        state_r   <= (cmd == OP_WRITE) ? ST_FINISH : ST_RUN;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        // Command is dropped, not retried.
                        err_timeout <= 1'b1;
                        cmd_valid   <= 1'b0;
                        cmd         <= OP_IDLE;
                        state_r     <= ST_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
                    end
                end
                ST_RUN: begin
                    if (!busy) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FINISH: begin
                    if (done) begin
                        seq_done <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cmd       <= OP_IDLE;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Testbench for lcd_cmd_seq: directed pushes, a busy responder, and a
// scoreboard of expected offered opcodes checked by an independent monitor.
module tb_lcd_cmd_seq;

    logic       clk;
    logic       reset;
    logic [3:0] host_cmd;
    logic       host_push;
    logic       host_full;
    logic [3:0] fifo_count;
    logic       busy;
    logic       done;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       seq_done;
    logic       err_overflow;
    logic       err_illegal;
    logic       err_timeout;

    logic       busy_hold;
    logic       resp_busy;
    logic       resp_en;
    int         resp_len;

    int         n_checks;
    int         n_fail;
    logic [3:0] sb[$];

    assign busy = busy_hold | resp_busy;

    lcd_cmd_seq #(.DEPTH(8), .TMO(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .host_cmd     (host_cmd),
        .host_push    (host_push),
        .host_full    (host_full),
        .fifo_count   (fifo_count),
        .busy         (busy),
        .done         (done),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .seq_done     (seq_done),
        .err_overflow (err_overflow),
        .err_illegal  (err_illegal),
        .err_timeout  (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every new offer must match the scoreboard head; cmd returns to F after.
    initial begin
        logic       prev_v;
        logic [3:0] e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_offer: got cmd %0h, expected no offer (t=%0t)", cmd, $time);
                end else begin
                    e = sb.pop_front();
                    check("offer_cmd", {28'd0, cmd}, {28'd0, e});
                end
            end
            if (!cmd_valid && prev_v) begin
                check("idle_opcode", {28'd0, cmd}, 32'hF);
            end
            prev_v = cmd_valid;
        end
    end

    // Responder: answers each offer with resp_len cycles of busy.
    initial begin
        resp_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && cmd_valid) begin
                resp_busy = 1'b1;
                repeat (resp_len) @(negedge clk);
                resp_busy = 1'b0;
            end
        end
    end

    task automatic push(input logic [3:0] v);
        @(negedge clk);
        host_cmd  = v;
        host_push = 1'b1;
        @(negedge clk);
        host_push = 1'b0;
        host_cmd  = 4'h0;
    endtask

    task automatic do_reset();
        check("sb_drained", sb.size(), 32'd0);
        sb.delete();
        resp_en   = 1'b0;
        busy_hold = 1'b0;
        host_push = 1'b0;
        done      = 1'b0;
        reset     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd", {28'd0, cmd}, 32'hF);
        check("rst_flags", {26'd0, cmd_valid, seq_done, err_overflow, err_illegal,
                            err_timeout, host_full}, 32'd0);
        check("rst_count", {28'd0, fifo_count}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(sb.size() == 0 && !cmd_valid && !busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_wait: got no idle within 200 cycles, expected idle", name);
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!cmd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_wait: got no cmd_valid within 50 cycles, expected offer", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running, expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int len;
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        host_cmd  = 4'h0;
        host_push = 1'b0;
        done      = 1'b0;
        busy_hold = 1'b0;
        resp_en   = 1'b0;
        resp_len  = 2;

        // Basic issue: 4,1,9 offered in order with 2-cycle busy responses.
        do_reset();
        busy_hold = 1'b1;
        repeat (10) @(negedge clk);
        busy_hold = 1'b0;
        resp_en   = 1'b1;
        resp_len  = 2;
        sb.push_back(4'd4); sb.push_back(4'd1); sb.push_back(4'd9);
        push(4'd4); push(4'd1); push(4'd9);
        wait_idle("basic");
        repeat (3) @(negedge clk);
        check("basic_count", {28'd0, fifo_count}, 32'd0);

        // Overflow: busy stuck high, 10 pushes into 8 entries.
        do_reset();
        busy_hold = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            push(4'(i));
            if (i == 7) check("ovf_not_full7", {31'd0, host_full}, 32'd0);
            if (i == 8) check("ovf_full8", {31'd0, host_full}, 32'd1);
            if (i == 8) check("ovf_noerr8", {31'd0, err_overflow}, 32'd0);
            if (i == 9) check("ovf_err9", {31'd0, err_overflow}, 32'd1);
        end
        check("ovf_count", {28'd0, fifo_count}, 32'd8);
        check("ovf_no_valid", {31'd0, cmd_valid}, 32'd0);

        // Illegal opcode: 13 discarded with err_illegal, then 2 offered once.
        do_reset();
        resp_en  = 1'b1;
        resp_len = 2;
        sb.push_back(4'd2);
        push(4'd13);
        check("ill_before_pop", {31'd0, err_illegal}, 32'd0);
        push(4'd2);
        check("ill_after_pop", {31'd0, err_illegal}, 32'd1);
        wait_idle("illegal");
        repeat (3) @(negedge clk);
        check("ill_count", {28'd0, fifo_count}, 32'd0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        check("done_ignored_idle", {31'd0, seq_done}, 32'd0);

        // Write/finish: 7 and 0 issued, 3 stays queued, done sets seq_done.
        do_reset();
        resp_en  = 1'b1;
        resp_len = 3;
        sb.push_back(4'd7); sb.push_back(4'd0);
        push(4'd7); push(4'd0); push(4'd3);
        wait_idle("finish");
        repeat (3) @(negedge clk);
        check("fin_count", {28'd0, fifo_count}, 32'd1);
        check("fin_pre_done", {31'd0, seq_done}, 32'd0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("fin_seq_done", {31'd0, seq_done}, 32'd1);
        repeat (4) @(negedge clk);
        check("fin_sticky", {31'd0, seq_done}, 32'd1);

        // Timeout: 5 offered for exactly 4 cycles, then 6 offered normally.
        do_reset();
        resp_en = 1'b0;
        sb.push_back(4'd5);
        push(4'd5);
        wait_valid("tmo");
        len = 0;
        while (cmd_valid && len < 20) begin
            len++;
            @(negedge clk);
        end
        check("tmo_len", len, 32'd4);
        check("tmo_err", {31'd0, err_timeout}, 32'd1);
        check("tmo_cmd", {28'd0, cmd}, 32'hF);
        resp_en  = 1'b1;
        resp_len = 2;
        sb.push_back(4'd6);
        push(4'd6);
        wait_idle("tmo_retry");
        check("tmo_retry_count", {28'd0, fifo_count}, 32'd0);

        // Mid-operation reset while offering 2 with 3 queued; err_timeout still set.
        resp_en = 1'b0;
        sb.push_back(4'd2);
        push(4'd2);
        push(4'd3);
        wait_valid("mrst");
        #2;
        reset = 1'b0;
        #1;
        check("mrst_valid", {31'd0, cmd_valid}, 32'd0);
        check("mrst_cmd", {28'd0, cmd}, 32'hF);
        check("mrst_count", {28'd0, fifo_count}, 32'd0);
        check("mrst_flags", {28'd0, seq_done, err_overflow, err_illegal, err_timeout}, 32'd0);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
